// File: rtl/serial_word_collector.sv
// Collects a qualified serial bit stream into WIDTH-bit parallel words, strobing each completed
// word, flagging frames aborted mid-word and keeping a saturating completed-word count.
module serial_word_collector #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
  input  logic             IN_Valid,
  output logic [WIDTH-1:0] Word,
  output logic             Word_Valid,
  output logic             Frame_Err,
  output logic             Busy,
  output logic [CNT_W-1:0] Word_Count
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next, w_assembled;
  logic [CW-1:0]    r_cnt, w_cnt_next, w_pos;
  logic [WIDTH-1:0] r_word, w_word_next;
  logic             r_word_valid, w_word_valid_next;
  logic             r_frame_err, w_frame_err_next;
  logic             r_busy, w_busy_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             w_last;

  // Destination bit of the current sample; the counter is 0 in IDLE so this covers bit 0 too.
  assign w_pos  = LSB_FIRST ? r_cnt : (CW'(WIDTH - 1) - r_cnt);
  assign w_last = (r_state == StShift) && (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_assembled        = (r_state == StIdle) ? '0 : r_shift;
    w_assembled[w_pos] = IN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (IN_Valid) w_state_next = StShift;
      StShift: if (!IN_Valid || w_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_shift_next      = r_shift;
    w_cnt_next        = r_cnt;
    w_word_next       = r_word;
    w_word_valid_next = 1'b0;
    w_frame_err_next  = 1'b0;
    w_count_next      = r_count;
    w_busy_next       = (w_state_next == StShift);
    unique case (r_state)
      StIdle: begin
        if (IN_Valid) begin
          w_shift_next = w_assembled;
          w_cnt_next   = CW'(1);
        end
      end
      StShift: begin
        if (!IN_Valid) begin
          w_frame_err_next = 1'b1;
          w_shift_next     = '0;
          w_cnt_next       = '0;
        end else if (w_last) begin
          w_word_next       = w_assembled;
          w_word_valid_next = 1'b1;
          w_shift_next      = '0;
          w_cnt_next        = '0;
          if (r_count != {CNT_W{1'b1}}) w_count_next = r_count + CNT_W'(1);
        end else begin
          w_shift_next = w_assembled;
          w_cnt_next   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_shift_next = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
      r_count      <= '0;
    end else begin
      r_shift      <= w_shift_next;
      r_cnt        <= w_cnt_next;
      r_word       <= w_word_next;
      r_word_valid <= w_word_valid_next;
      r_frame_err  <= w_frame_err_next;
      r_busy       <= w_busy_next;
      r_count      <= w_count_next;
    end
  end

  assign Word       = r_word;
  assign Word_Valid = r_word_valid;
  assign Frame_Err  = r_frame_err;
  assign Busy       = r_busy;
  assign Word_Count = r_count;

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench: three collector variants (LSB-first, MSB-first, 2-bit counter) share one
// input stream and are checked against directed tables and a bit-queue reference model.
module tb_serial_word_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;

  logic [7:0] word_l, word_m, word_s;
  logic       wv_l, wv_m, wv_s, fe_l, fe_m, fe_s, busy_l, busy_m, busy_s;
  logic [7:0] cnt_l, cnt_m;
  logic [1:0] cnt_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_word_collector #(.WIDTH(8), .LSB_FIRST(1'b1), .CNT_W(8)) u_l (
    .CLK(clk), .RST(rst), .IN(in_bit), .IN_Valid(in_valid), .Word(word_l), .Word_Valid(wv_l),
    .Frame_Err(fe_l), .Busy(busy_l), .Word_Count(cnt_l));
  serial_word_collector #(.WIDTH(8), .LSB_FIRST(1'b0), .CNT_W(8)) u_m (
    .CLK(clk), .RST(rst), .IN(in_bit), .IN_Valid(in_valid), .Word(word_m), .Word_Valid(wv_m),
    .Frame_Err(fe_m), .Busy(busy_m), .Word_Count(cnt_m));
  serial_word_collector #(.WIDTH(8), .LSB_FIRST(1'b1), .CNT_W(2)) u_s (
    .CLK(clk), .RST(rst), .IN(in_bit), .IN_Valid(in_valid), .Word(word_s), .Word_Valid(wv_s),
    .Frame_Err(fe_s), .Busy(busy_s), .Word_Count(cnt_s));

  // Reference model: received bits of the current frame in arrival order, plus totals.
  int         m_n;
  logic [7:0] m_bits;
  logic [7:0] m_wl, m_wm;
  int         m_cnt;
  logic       m_wv, m_fe;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_n = 0; m_bits = '0; m_wl = '0; m_wm = '0; m_cnt = 0; m_wv = 0; m_fe = 0;
  endtask

  task automatic model_update(input logic v, input logic b);
    m_wv = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      m_bits[m_n] = b;
      m_n++;
      if (m_n == 8) begin
        m_wl = m_bits;
        for (int k = 0; k < 8; k++) m_wm[7-k] = m_bits[k];
        m_cnt++;
        m_wv = 1'b1;
        m_n = 0;
      end
    end else if (m_n > 0) begin
      m_fe = 1'b1;
      m_n = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic mb;
    mb = (m_n > 0);
    chk("model wv_l", 32'(wv_l), 32'(m_wv));
    chk("model wv_m", 32'(wv_m), 32'(m_wv));
    chk("model wv_s", 32'(wv_s), 32'(m_wv));
    chk("model fe_l", 32'(fe_l), 32'(m_fe));
    chk("model fe_m", 32'(fe_m), 32'(m_fe));
    chk("model fe_s", 32'(fe_s), 32'(m_fe));
    chk("model busy_l", 32'(busy_l), 32'(mb));
    chk("model busy_s", 32'(busy_s), 32'(mb));
    chk("model word_l", 32'(word_l), 32'(m_wl));
    chk("model word_m", 32'(word_m), 32'(m_wm));
    chk("model word_s", 32'(word_s), 32'(m_wl));
    chk("model cnt_l", 32'(cnt_l), 32'(sat(m_cnt, 255)));
    chk("model cnt_m", 32'(cnt_m), 32'(sat(m_cnt, 255)));
    chk("model cnt_s", 32'(cnt_s), 32'(sat(m_cnt, 3)));
  endtask

  // Called at a falling edge: drive, let the rising edge sample, compare at the next fall.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    model_update(v, b);
    @(negedge clk);
    chk_model();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " word_l"}, 32'(word_l), 0);
    chk({tag, " word_m"}, 32'(word_m), 0);
    chk({tag, " wv_l"}, 32'(wv_l), 0);
    chk({tag, " fe_l"}, 32'(fe_l), 0);
    chk({tag, " busy_l"}, 32'(busy_l), 0);
    chk({tag, " busy_m"}, 32'(busy_m), 0);
    chk({tag, " cnt_l"}, 32'(cnt_l), 0);
    chk({tag, " cnt_s"}, 32'(cnt_s), 0);
  endtask

  typedef struct {
    int         nbits;
    logic [7:0] data;
    logic [7:0] exp_l;
    logic [7:0] exp_m;
    int         exp_cnt;
    int         exp_cnt_s;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];
  int   sat_exp[5];

  initial begin
    // Consecutive frames from reset; a 5-bit frame aborts and leaves Word/count untouched.
    vecs[0] = '{8, 8'h59, 8'h59, 8'h9A, 1, 1, 1'b0};
    vecs[1] = '{8, 8'hA5, 8'hA5, 8'hA5, 2, 2, 1'b0};
    vecs[2] = '{5, 8'h13, 8'hA5, 8'hA5, 2, 2, 1'b1};
    vecs[3] = '{8, 8'h3C, 8'h3C, 8'h3C, 3, 3, 1'b0};
    vecs[4] = '{8, 8'h01, 8'h01, 8'h80, 4, 3, 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};

    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("post-reset");

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vecs[i].nbits; k++) begin
        step(1'b1, vecs[i].data[k]);
        if (k < vecs[i].nbits - 1) begin
          chk("vec mid busy", 32'(busy_l), 1);
          chk("vec mid wv", 32'(wv_l), 0);
          chk("vec mid fe", 32'(fe_l), 0);
        end
      end
      if (vecs[i].nbits < 8) step(1'b0, 1'(($urandom() & 1)));
      chk("vec wv", 32'(wv_l), 32'(!vecs[i].exp_err));
      chk("vec fe", 32'(fe_l), 32'(vecs[i].exp_err));
      chk("vec busy", 32'(busy_l), 0);
      chk("vec word_l", 32'(word_l), 32'(vecs[i].exp_l));
      chk("vec word_m", 32'(word_m), 32'(vecs[i].exp_m));
      chk("vec cnt_l", 32'(cnt_l), 32'(vecs[i].exp_cnt));
      chk("vec cnt_s", 32'(cnt_s), 32'(vecs[i].exp_cnt_s));
    end

    // Asynchronous reset mid-frame, asserted between clock edges.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
    chk("pre-rst busy", 32'(busy_l), 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst release");

    // Five full frames after reset: the 2-bit counter saturates.
    for (int f = 0; f < 5; f++) begin
      logic [7:0] d;
      d = 8'($urandom());
      for (int k = 0; k < 8; k++) step(1'b1, d[k]);
      chk("sat word_l", 32'(word_l), 32'(d));
      chk("sat cnt_l", 32'(cnt_l), 32'(f + 1));
      chk("sat cnt_s", 32'(cnt_s), 32'(sat_exp[f]));
    end

    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 9) != 0), 1'(($urandom() & 1)));
    end
    step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
